// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int          INSTR_BYTES       = 4;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Occupancy of the IF/ID register; this is the only control state in the stage.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } if_id_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'(INSTR_BYTES);
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, memory address, and the IF/ID register with valid/ready to decode.
// Optional perf counters are compiled in when FETCH_PERF_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        misalign_flag
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
`endif
);

  fetch_state_e state_p1, state_nxt;
  logic [31:0]  pc_p0, pc_nxt;
  if_id_t       if_id_p1, if_id_nxt;
  logic         misalign_q, misalign_nxt;
  logic         adv;

  // Stage 0: program counter addresses the memory directly
  assign imem_addr = pc_p0;

  always_comb begin
    state_nxt    = state_p1;
    pc_nxt       = pc_p0;
    if_id_nxt    = if_id_p1;
    misalign_nxt = misalign_q;
    adv          = (state_p1 == ST_EMPTY) || id_ready;

    if (redirect_valid) begin
      // Wrong-path word is flushed; id_pc/id_pc_plus4 keep their last values.
      state_nxt       = ST_EMPTY;
      pc_nxt          = word_align(redirect_pc);
      if_id_nxt.instr = NOP_INSTR;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_nxt = 1'b1;
      end
    end else if (adv) begin
      state_nxt          = ST_FULL;
      if_id_nxt.pc       = pc_p0;
      if_id_nxt.instr    = imem_instr;
      if_id_nxt.pc_plus4 = pc_inc(pc_p0);
      pc_nxt             = pc_inc(pc_p0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1   <= ST_EMPTY;
      pc_p0      <= word_align(RESET_PC);
      if_id_p1   <= '{pc: 32'h0, instr: NOP_INSTR, pc_plus4: 32'h0};
      misalign_q <= 1'b0;
    end else begin
      state_p1   <= state_nxt;
      pc_p0      <= pc_nxt;
      if_id_p1   <= if_id_nxt;
      misalign_q <= misalign_nxt;
    end
  end

  // Stage 1: IF/ID register presented to decode
  assign id_valid      = (state_p1 == ST_FULL);
  assign id_pc         = if_id_p1.pc;
  assign id_instr      = if_id_p1.instr;
  assign id_pc_plus4   = if_id_p1.pc_plus4;
  assign misalign_flag = misalign_q;

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] fetched_q, stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= 32'h0;
      stalls_q  <= 32'h0;
    end else begin
      if (id_valid && id_ready) begin
        fetched_q <= sat_inc(fetched_q);
      end
      if (id_valid && !id_ready) begin
        stalls_q <= sat_inc(stalls_q);
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a cycle model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        misalign_flag;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .id_pc_plus4   (id_pc_plus4),
    .misalign_flag (misalign_flag)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stalls   (perf_stalls)
`endif
  );

  // Instruction memory: 64 words at the bottom of the map, a fixed hash elsewhere.
  logic [31:0] mem [0:63];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:8] == 24'h0) return mem[a[7:2]];
    return a ^ 32'h5A5A_0000;
  endfunction

  always_comb imem_instr = mem_word(imem_addr);

  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural view of the stage, one call per clock edge.
  logic [31:0] m_pc, m_ipc, m_instr, m_p4, m_fetched, m_stalls;
  logic        m_valid, m_mis;

  task automatic step();
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_ipc = 32'h0; m_instr = NOP; m_p4 = 32'h0;
      m_mis = 1'b0; m_fetched = 32'h0; m_stalls = 32'h0;
    end else begin
      if (m_valid && id_ready && m_fetched != 32'hFFFF_FFFF) m_fetched = m_fetched + 1;
      if (m_valid && !id_ready && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
      if (redirect_valid) begin
        if (redirect_pc % 4 != 0) m_mis = 1'b1;
        m_pc = redirect_pc - (redirect_pc % 4);
        m_valid = 1'b0;
        m_instr = NOP;
      end else if (!m_valid || id_ready) begin
        m_ipc = m_pc; m_instr = mem_word(m_pc); m_p4 = m_pc + 4;
        m_valid = 1'b1;
        m_pc = m_pc + 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    id_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0022;
    rst = 1'b1;
    step();
    redirect_valid = 1'b0;
    rst = 1'b0;
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h exp=%h", imem_addr, 32'h0); end
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
    n_cmp++; if (id_pc !== 32'h0) begin n_bad++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
    n_cmp++; if (id_instr !== NOP) begin n_bad++; $display("FAIL reset_instr got=%h exp=%h", id_instr, NOP); end
    n_cmp++; if (id_pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL reset_p4 got=%h exp=0", id_pc_plus4); end
    n_cmp++; if (misalign_flag !== 1'b0) begin n_bad++; $display("FAIL reset_misalign got=%b exp=0", misalign_flag); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (perf_fetched !== 32'h0 || perf_stalls !== 32'h0) begin
      n_bad++; $display("FAIL reset_perf got=%h/%h exp=0/0", perf_fetched, perf_stalls);
    end
`endif
  endtask

  task automatic test_sequential();
    logic [31:0] exp_instr [0:3];
    exp_instr[0] = 32'h1234_5678; exp_instr[1] = 32'h9ABC_DEF0;
    exp_instr[2] = mem[2];        exp_instr[3] = 32'hCAFE_BABE;
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (imem_addr !== 32'(4 * i)) begin n_bad++; $display("FAIL seq_addr%0d got=%h exp=%h", i, imem_addr, 32'(4 * i)); end
      step();
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'(4 * i) || id_instr !== exp_instr[i] || id_pc_plus4 !== 32'(4 * i + 4)) begin
        n_bad++; $display("FAIL seq_ifid%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", i, id_valid, id_pc, id_instr, id_pc_plus4,
                          32'(4 * i), exp_instr[i], 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    id_ready = 1'b1;
    step();
    step();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_instr !== 32'h9ABC_DEF0 || imem_addr !== 32'h8) begin
        n_bad++; $display("FAIL stall_hold%0d got=%b/%h/%h/%h exp=1/4/9abcdef0/8", i, id_valid, id_pc, id_instr, imem_addr);
      end
    end
    id_ready = 1'b1;
    step();
    n_cmp++; if (id_pc !== 32'h8 || id_instr !== mem[2]) begin
      n_bad++; $display("FAIL stall_release got=%h/%h exp=8/%h", id_pc, id_instr, mem[2]);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    id_ready = 1'b1;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'hC;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (id_valid !== 1'b0 || id_instr !== NOP || imem_addr !== 32'hC) begin
      n_bad++; $display("FAIL redir_flush got=%b/%h/%h exp=0/%h/c", id_valid, id_instr, imem_addr, NOP);
    end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'hC || id_instr !== 32'hCAFE_BABE) begin
      n_bad++; $display("FAIL redir_target got=%b/%h/%h exp=1/c/cafebabe", id_valid, id_pc, id_instr);
    end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h6; id_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (imem_addr !== 32'h4 || misalign_flag !== 1'b1) begin
      n_bad++; $display("FAIL misalign_set got=%h/%b exp=4/1", imem_addr, misalign_flag);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h10; id_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    n_cmp++; if (misalign_flag !== 1'b1) begin n_bad++; $display("FAIL misalign_sticky got=%b exp=1", misalign_flag); end
  endtask

  task automatic test_rst_mid_and_wrap();
    do_reset();
    id_ready = 1'b1;
    step(); step(); step();
    n_cmp++; if (imem_addr !== 32'hC) begin n_bad++; $display("FAIL mid_pre got=%h exp=c", imem_addr); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (imem_addr !== 32'h0 || id_valid !== 1'b0 || misalign_flag !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset got=%h/%b/%b exp=0/0/0", imem_addr, id_valid, misalign_flag);
    end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    n_cmp++; if (imem_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0 || misalign_flag !== 1'b0) begin
      n_bad++; $display("FAIL wrap got=%h/%h/%h/%b exp=0/fffffffc/0/0", imem_addr, id_pc, id_pc_plus4, misalign_flag);
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    id_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_cmp++; if (perf_fetched !== 32'd4 || perf_stalls !== 32'd3) begin
      n_bad++; $display("FAIL perf_counts got=%0d/%0d exp=4/3", perf_fetched, perf_stalls);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 79) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
      step();
      n_cmp++; if (imem_addr !== m_pc || id_valid !== m_valid || id_pc !== m_ipc || id_instr !== m_instr ||
                   id_pc_plus4 !== m_p4 || misalign_flag !== m_mis) begin
        n_bad++; $display("FAIL rand%0d got=%h/%b/%h/%h/%h/%b exp=%h/%b/%h/%h/%h/%b", i, imem_addr, id_valid, id_pc,
                          id_instr, id_pc_plus4, misalign_flag, m_pc, m_valid, m_ipc, m_instr, m_p4, m_mis);
      end
`ifdef FETCH_PERF_EN
      n_cmp++; if (perf_fetched !== m_fetched || perf_stalls !== m_stalls) begin
        n_bad++; $display("FAIL rand_perf%0d got=%0d/%0d exp=%0d/%0d", i, perf_fetched, perf_stalls, m_fetched, m_stalls);
      end
`endif
    end
    rst = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h1234_5678;
    mem[1] = 32'h9ABC_DEF0;
    mem[3] = 32'hCAFE_BABE;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misalign();
    test_rst_mid_and_wrap();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
